// File: rtl/lsm_pkg.sv
// Shared definitions for the LDM/STM register-list sequencer: command codes, states, opcode.
package lsm_pkg;

  localparam int unsigned ListW   = 16;
  localparam int unsigned RegBits = 4;
  localparam int unsigned CntW    = 5;

  localparam logic [2:0] LSM_NOP   = 3'b000;
  localparam logic [2:0] LSM_START = 3'b001;
  localparam logic [2:0] LSM_STEP  = 3'b010;
  localparam logic [2:0] LSM_ABORT = 3'b011;

  // IR[27:25] for the block data transfer class
  localparam logic [2:0] LSM_OPCODE = 3'b100;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDone   = 2'd2
  } lsm_state_e;

  function automatic logic [CntW-1:0] popcount16(input logic [ListW-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(ListW); i++) begin
      c = c + CntW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lsm_sequencer_if.sv
// Command/IR inputs and per-transfer outputs between the control unit and the LSM sequencer.
interface lsm_sequencer_if;
  import lsm_pkg::*;

  logic               lsm_en;
  logic [2:0]         lsm_in;
  logic [31:0]        ir;
  logic               lsm_detect;
  logic               lsm_end;
  logic               busy;
  logic [RegBits-1:0] reg_sel;
  logic [CntW-1:0]    xfer_cnt;
  logic [31:0]        addr_ofs;
  logic [31:0]        wb_ofs;

  modport master (
    output lsm_en, lsm_in, ir,
    input  lsm_detect, lsm_end, busy, reg_sel, xfer_cnt, addr_ofs, wb_ofs
  );

  modport slave (
    input  lsm_en, lsm_in, ir,
    output lsm_detect, lsm_end, busy, reg_sel, xfer_cnt, addr_ofs, wb_ofs
  );
endinterface

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit encoder for a 16-bit register list, with a non-empty flag.
module lsm_prio_enc
  import lsm_pkg::*;
(
  input  logic [ListW-1:0]   list,
  output logic [RegBits-1:0] idx,
  output logic               valid
);

  // Scan downward so the lowest set bit is the last assignment to win
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(ListW) - 1; i >= 0; i--) begin
      if (list[i]) begin
        idx   = RegBits'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest-first and supplies start/writeback offsets.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int unsigned WordBytes = 4
) (
  input logic             clk,
  input logic             rst_n,
  lsm_sequencer_if.slave  bus
);

  lsm_state_e         state_q, state_d;
  logic [ListW-1:0]   list_q, list_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RegBits-1:0] reg_sel_q, reg_sel_d;
  logic [31:0]        addr_ofs_q, addr_ofs_d;
  logic [31:0]        wb_ofs_q, wb_ofs_d;

  logic [ListW-1:0]   list_clr;
  logic [ListW-1:0]   enc_in;
  logic [RegBits-1:0] enc_idx;
  logic               enc_valid;
  logic               is_start;
  logic [CntW-1:0]    n;
  logic [31:0]        nbytes;
  logic               p_bit, u_bit;
  logic               unused_ir;

  assign list_clr  = list_q & (list_q - ListW'(1));
  assign is_start  = bus.lsm_en && (bus.lsm_in == LSM_START);
  assign enc_in    = is_start ? bus.ir[15:0] : list_clr;
  assign n         = popcount16(bus.ir[15:0]);
  assign nbytes    = 32'(n) * 32'(WordBytes);
  assign p_bit     = bus.ir[24];
  assign u_bit     = bus.ir[23];
  assign unused_ir = ^{bus.ir[31:28], bus.ir[22:16]};

  lsm_prio_enc u_prio_enc (
    .list  (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    cnt_d      = cnt_q;
    reg_sel_d  = reg_sel_q;
    addr_ofs_d = addr_ofs_q;
    wb_ofs_d   = wb_ofs_q;
    if (bus.lsm_en) begin
      case (bus.lsm_in)
        LSM_START: begin
          list_d    = bus.ir[15:0];
          cnt_d     = n;
          reg_sel_d = enc_idx;
          if (n == '0) begin
            state_d    = StDone;
            addr_ofs_d = '0;
            wb_ofs_d   = '0;
          end else begin
            state_d = StActive;
            case ({p_bit, u_bit})
              2'b01:   addr_ofs_d = '0;
              2'b11:   addr_ofs_d = 32'(WordBytes);
              2'b00:   addr_ofs_d = 32'(WordBytes) - nbytes;
              default: addr_ofs_d = 32'd0 - nbytes;
            endcase
            wb_ofs_d = u_bit ? nbytes : 32'd0 - nbytes;
          end
        end
        LSM_STEP: begin
          if (state_q == StActive) begin
            if (cnt_q == CntW'(1)) begin
              state_d = StDone;
              list_d  = '0;
              cnt_d   = '0;
            end else begin
              list_d = list_clr;
              cnt_d  = cnt_q - CntW'(1);
              if (enc_valid) reg_sel_d = enc_idx;
            end
          end
        end
        LSM_ABORT: begin
          state_d = StIdle;
          list_d  = '0;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      list_q     <= '0;
      cnt_q      <= '0;
      reg_sel_q  <= '0;
      addr_ofs_q <= '0;
      wb_ofs_q   <= '0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      cnt_q      <= cnt_d;
      reg_sel_q  <= reg_sel_d;
      addr_ofs_q <= addr_ofs_d;
      wb_ofs_q   <= wb_ofs_d;
    end
  end

  assign bus.lsm_detect = (bus.ir[27:25] == LSM_OPCODE);
  assign bus.busy       = (state_q == StActive);
  assign bus.lsm_end    = ((state_q == StActive) && (cnt_q == CntW'(1))) || (state_q == StDone);
  assign bus.reg_sel    = reg_sel_q;
  assign bus.xfer_cnt   = cnt_q;
  assign bus.addr_ofs   = addr_ofs_q;
  assign bus.wb_ofs     = wb_ofs_q;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer: expected snapshots queued per command, compared after the edge.
module tb_lsm_sequencer;
  import lsm_pkg::*;

  typedef struct {
    string       tag;
    logic        busy;
    logic        lend;
    logic [3:0]  rs;
    logic [4:0]  cnt;
    logic [31:0] ao;
    logic [31:0] wo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  lsm_sequencer_if bus ();

  lsm_sequencer #(
    .WordBytes (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".busy"},     32'(bus.busy),     32'(e.busy));
    chk({e.tag, ".end"},      32'(bus.lsm_end),  32'(e.lend));
    chk({e.tag, ".reg_sel"},  32'(bus.reg_sel),  32'(e.rs));
    chk({e.tag, ".xfer_cnt"}, 32'(bus.xfer_cnt), 32'(e.cnt));
    chk({e.tag, ".addr_ofs"}, bus.addr_ofs,      e.ao);
    chk({e.tag, ".wb_ofs"},   bus.wb_ofs,        e.wo);
  endtask

  task automatic cmd(input logic en, input logic [2:0] code, input string tag,
                     input logic b, input logic e, input logic [3:0] rs, input logic [4:0] cnt,
                     input logic [31:0] ao, input logic [31:0] wo);
    exp_t x;
    @(negedge clk);
    bus.lsm_en = en;
    bus.lsm_in = code;
    sb.push_back('{tag: tag, busy: b, lend: e, rs: rs, cnt: cnt, ao: ao, wo: wo});
    @(posedge clk);
    #1;
    bus.lsm_en = 1'b0;
    bus.lsm_in = LSM_NOP;
    x = sb.pop_front();
    chk_all(x);
  endtask

  initial begin
    exp_t z;
    errors = 0;
    checks = 0;
    rst_n      = 1'b0;
    bus.lsm_en = 1'b0;
    bus.lsm_in = LSM_NOP;
    bus.ir     = 32'h0;
    z = '{tag: "reset", busy: 1'b0, lend: 1'b0, rs: 4'd0, cnt: 5'd0, ao: 32'd0, wo: 32'd0};
    #12;
    chk_all(z);
    @(negedge clk);
    rst_n = 1'b1;

    // LDMIA R0!,{R1,R3,R7}
    bus.ir = 32'hE8B0008A;
    #1;
    chk("ldmia.detect", 32'(bus.lsm_detect), 32'd1);
    cmd(1, LSM_START, "ia.start", 1, 0, 4'd1, 5'd3, 32'h0, 32'hC);
    cmd(1, LSM_STEP,  "ia.step1", 1, 0, 4'd3, 5'd2, 32'h0, 32'hC);
    cmd(1, LSM_STEP,  "ia.step2", 1, 1, 4'd7, 5'd1, 32'h0, 32'hC);
    cmd(1, LSM_STEP,  "ia.done",  0, 1, 4'd7, 5'd0, 32'h0, 32'hC);

    // STMDB R13!,{R4-R6,R14}
    bus.ir = 32'hE92D4070;
    cmd(1, LSM_START, "db.start", 1, 0, 4'd4,  5'd4, 32'hFFFFFFF0, 32'hFFFFFFF0);
    cmd(1, LSM_STEP,  "db.s5",    1, 0, 4'd5,  5'd3, 32'hFFFFFFF0, 32'hFFFFFFF0);
    cmd(1, LSM_STEP,  "db.s6",    1, 0, 4'd6,  5'd2, 32'hFFFFFFF0, 32'hFFFFFFF0);
    cmd(1, LSM_STEP,  "db.s14",   1, 1, 4'd14, 5'd1, 32'hFFFFFFF0, 32'hFFFFFFF0);
    cmd(1, LSM_STEP,  "db.done",  0, 1, 4'd14, 5'd0, 32'hFFFFFFF0, 32'hFFFFFFF0);

    // LDMDA, all sixteen registers
    bus.ir = 32'hE811FFFF;
    cmd(1, LSM_START, "da16.start", 1, 0, 4'd0, 5'd16, 32'hFFFFFFC4, 32'hFFFFFFC0);
    for (int i = 1; i < 16; i++) begin
      cmd(1, LSM_STEP, $sformatf("da16.s%0d", i), 1, (i == 15), 4'(i), 5'(16 - i),
          32'hFFFFFFC4, 32'hFFFFFFC0);
    end
    cmd(1, LSM_STEP, "da16.done", 0, 1, 4'd15, 5'd0, 32'hFFFFFFC4, 32'hFFFFFFC0);

    // Empty list goes straight to DONE
    bus.ir = 32'hE8900000;
    cmd(1, LSM_START, "empty.start", 0, 1, 4'd0, 5'd0, 32'h0, 32'h0);
    cmd(1, LSM_STEP,  "empty.step",  0, 1, 4'd0, 5'd0, 32'h0, 32'h0);

    // LDR: not detected; strobe low means hold
    bus.ir = 32'hE5901000;
    #1;
    chk("ldr.detect", 32'(bus.lsm_detect), 32'd0);
    cmd(0, LSM_STEP, "en0.hold", 0, 1, 4'd0, 5'd0, 32'h0, 32'h0);

    // Asynchronous reset mid-sequence
    bus.ir = 32'hE8B0008A;
    cmd(1, LSM_START, "rst.start", 1, 0, 4'd1, 5'd3, 32'h0, 32'hC);
    cmd(1, LSM_STEP,  "rst.step",  1, 0, 4'd3, 5'd2, 32'h0, 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    z.tag = "async_rst";
    chk_all(z);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort, then restart while active; IR changes mid-sequence are ignored
    cmd(1, LSM_START, "ab.start", 1, 0, 4'd1, 5'd3, 32'h0, 32'hC);
    cmd(1, LSM_STEP,  "ab.step",  1, 0, 4'd3, 5'd2, 32'h0, 32'hC);
    cmd(1, LSM_ABORT, "ab.abort", 0, 0, 4'd3, 5'd0, 32'h0, 32'hC);
    cmd(1, LSM_STEP,  "ab.idle",  0, 0, 4'd3, 5'd0, 32'h0, 32'hC);
    cmd(1, LSM_START, "rs.start", 1, 0, 4'd1, 5'd3, 32'h0, 32'hC);
    cmd(1, LSM_STEP,  "rs.step",  1, 0, 4'd3, 5'd2, 32'h0, 32'hC);
    cmd(1, LSM_START, "rs.again", 1, 0, 4'd1, 5'd3, 32'h0, 32'hC);
    bus.ir = 32'hE5901000;
    cmd(1, LSM_STEP,  "irchg.step", 1, 0, 4'd3, 5'd2, 32'h0, 32'hC);
    chk("irchg.detect", 32'(bus.lsm_detect), 32'd0);
    cmd(1, 3'b111,    "badcode.nop", 1, 0, 4'd3, 5'd2, 32'h0, 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
